mult_div_unit: RTL and testbench

- Iterative multiply/divide unit for the MIPS32 datapath.
- Directly downstream of the register bank: consumes the two read-port operands (rs, rt) and executes MULT, MULTU, DIV and DIVU over multiple cycles.
- Holds the architectural HI/LO registers, which are read back by MFHI/MFLO.
- Exposes a Busy/Done handshake so the control unit can stall.

---
 rtl/mult_div_unit.sv | 167 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Purpose: iterative MIPS32 MULT/MULTU/DIV/DIVU engine that owns the architectural HI/LO registers.
// Latency: Start accepted at edge T0 -> Done pulse with new Hi/Lo after edge T0+ITER+1.
// Backpressure: Busy is high while computing; Start and MTHI/MTLO are ignored until back in IDLE.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             HiWrite,
  input  logic             LoWrite,
  input  logic [WIDTH-1:0] WriteData,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d;        // |multiplicand|
  logic [WIDTH-1:0]     b_q, b_d;        // |divisor|
  logic [WIDTH-1:0]     raw_q, raw_d;    // dividend bits as presented, for divide-by-zero
  logic [2*WIDTH-1:0]   acc_q, acc_d;    // multiply: {partial, multiplier}; divide: {remainder, quotient}
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 negq_q, negq_d;  // product / quotient is negative
  logic                 negr_q, negr_d;  // remainder is negative (dividend sign)
  logic                 bz_q, bz_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 done_q, done_d, dbz_q, dbz_d;

  // Operand magnitudes: only MULT/DIV (Op[0]==0) interpret operands as signed.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  assign a_neg = ~Op[0] & OperandA[WIDTH-1];
  assign b_neg = ~Op[0] & OperandB[WIDTH-1];
  assign a_abs = a_neg ? -OperandA : OperandA;
  assign b_abs = b_neg ? -OperandB : OperandB;

  // Radix-2 step datapath and final sign correction.
  logic [WIDTH:0]       mul_sum, div_shift, div_sub;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
  assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_ge    = div_shift >= {1'b0, b_q};
  assign div_sub   = div_shift - {1'b0, b_q};
  assign prod_fix  = negq_q ? -acc_q : acc_q;
  assign quo_fix   = negq_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix   = negr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  // Next-state and datapath updates for IDLE/CALC/FIX.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    raw_d   = raw_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    bz_d    = bz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (HiWrite) hi_d = WriteData;
        if (LoWrite) lo_d = WriteData;
        if (Start) begin
          op_d    = Op;
          a_d     = a_abs;
          b_d     = b_abs;
          raw_d   = OperandA;
          negq_d  = a_neg ^ b_neg;
          negr_d  = a_neg;
          bz_d    = (OperandB == '0);
          acc_d   = Op[1] ? {{WIDTH{1'b0}}, a_abs} : {{WIDTH{1'b0}}, b_abs};
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q[1]) begin
          acc_d = {(div_ge ? div_sub[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                   acc_q[WIDTH-2:0], div_ge};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == CW'(ITER-1)) state_d = FIX;
      end
      FIX: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (op_q[1]) begin
          if (bz_q) begin
            lo_d  = '1;
            hi_d  = raw_q;
            dbz_d = 1'b1;
          end else begin
            lo_d = quo_fix;
            hi_d = rem_fix;
          end
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-low reset that abandons any operation.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      raw_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      bz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      raw_q   <= raw_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      bz_q    <= bz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign Busy      = (state_q != IDLE);
  assign Done      = done_q;
  assign DivByZero = dbz_q;
  assign Hi        = hi_q;
  assign Lo        = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus random operations,
// each compared against an arithmetic reference model of MIPS MULT/DIV semantics.
module tb_mult_div_unit;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [1:0]  Op = 2'b00;
  logic [31:0] OperandA = '0;
  logic [31:0] OperandB = '0;
  logic        HiWrite = 1'b0;
  logic        LoWrite = 1'b0;
  logic [31:0] WriteData = '0;
  logic        Busy, Done, DivByZero;
  logic [31:0] Hi, Lo;

  mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op),
    .OperandA(OperandA), .OperandB(OperandB),
    .HiWrite(HiWrite), .LoWrite(LoWrite), .WriteData(WriteData),
    .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .Hi(Hi), .Lo(Lo)
  );

  always #5 Clock = ~Clock;

  int nerr = 0;
  int nchk = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: {div_by_zero, hi, lo} from plain arithmetic.
  function automatic logic [64:0] ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      2'b00: begin p = sa * sb; return {1'b0, p}; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; return {1'b0, p}; end
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        if (op == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
          return {1'b0, r[31:0], q[31:0]};
        end
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  // Launch one op, optionally poke Start/MTHI/MTLO mid-flight at cycle 'poke', check result.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int poke);
    logic [64:0] e;
    int lat, busy_n;
    e = ref_op(op, a, b);
    Start = 1'b1; Op = op; OperandA = a; OperandB = b;
    @(posedge Clock); #1;
    Start = 1'b0; OperandA = $urandom; OperandB = $urandom; Op = 2'($urandom);
    lat = 0; busy_n = 0;
    while (Done !== 1'b1 && lat < 100) begin
      if (Busy === 1'b1) busy_n++;
      if (lat == poke) begin
        Start = 1'b1; Op = 2'b11; LoWrite = 1'b1; HiWrite = 1'b1; WriteData = 32'h0000_DEAD;
      end else begin
        Start = 1'b0; LoWrite = 1'b0; HiWrite = 1'b0;
      end
      @(posedge Clock); #1;
      lat++;
    end
    Start = 1'b0; LoWrite = 1'b0; HiWrite = 1'b0;
    chk("latency", 64'(lat), 64'd33);
    chk("busy_cycles", 64'(busy_n), 64'd33);
    chk("busy_at_done", {63'b0, Busy}, 64'd0);
    chk("hi", {32'b0, Hi}, {32'b0, e[63:32]});
    chk("lo", {32'b0, Lo}, {32'b0, e[31:0]});
    chk("div_by_zero", {63'b0, DivByZero}, {63'b0, e[64]});
    m_hi = e[63:32];
    m_lo = e[31:0];
  endtask

  task automatic idle_check(input string tag);
    @(posedge Clock); #1;
    chk({tag, "_done_low"}, {63'b0, Done}, 64'd0);
    chk({tag, "_dbz_low"}, {63'b0, DivByZero}, 64'd0);
    chk({tag, "_busy_low"}, {63'b0, Busy}, 64'd0);
    chk({tag, "_hi_hold"}, {32'b0, Hi}, {32'b0, m_hi});
    chk({tag, "_lo_hold"}, {32'b0, Lo}, {32'b0, m_lo});
  endtask

  initial begin
    int done_n;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    // Reset state
    Reset = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_busy", {63'b0, Busy}, 64'd0);
    chk("rst_done", {63'b0, Done}, 64'd0);
    chk("rst_dbz", {63'b0, DivByZero}, 64'd0);
    chk("rst_hi", {32'b0, Hi}, 64'd0);
    chk("rst_lo", {32'b0, Lo}, 64'd0);
    Reset = 1'b1;

    // MTHI / MTLO in IDLE
    HiWrite = 1'b1; WriteData = 32'h0000_1234;
    @(posedge Clock); #1;
    HiWrite = 1'b0;
    chk("mthi_hi", {32'b0, Hi}, 64'h1234);
    chk("mthi_lo", {32'b0, Lo}, 64'd0);
    LoWrite = 1'b1; WriteData = 32'h0000_5678;
    @(posedge Clock); #1;
    LoWrite = 1'b0;
    chk("mtlo_lo", {32'b0, Lo}, 64'h5678);
    chk("mtlo_hi", {32'b0, Hi}, 64'h1234);
    m_hi = 32'h1234; m_lo = 32'h5678;
    idle_check("mt_idle");

    // Directed arithmetic corner cases
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    chk("multu_max_hi_const", {32'b0, Hi}, 64'hFFFF_FFFE);
    chk("multu_max_lo_const", {32'b0, Lo}, 64'h0000_0001);
    idle_check("multu_max");
    do_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, -1);
    do_op(2'b00, 32'h8000_0000, 32'h8000_0000, -1);
    do_op(2'b11, 32'd100, 32'd7, -1);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, -1);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    chk("div_ovf_lo_const", {32'b0, Lo}, 64'h8000_0000);
    do_op(2'b11, 32'd5, 32'd0, -1);
    do_op(2'b01, 32'd2, 32'd3, -1);   // back-to-back on the Done cycle
    idle_check("b2b");

    // Start / MTLO / MTHI while busy must be ignored
    do_op(2'b01, 32'd3, 32'd4, 10);
    chk("busy_poke_lo_const", {32'b0, Lo}, 64'd12);
    idle_check("poke");

    // Random back-to-back operations
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = 32'h8000_0000;
      do_op(rop, ra, rb, -1);
    end
    idle_check("rand");

    // Reset in the middle of a DIV
    Start = 1'b1; Op = 2'b10; OperandA = 32'h1234_5678; OperandB = 32'd3;
    @(posedge Clock); #1;
    Start = 1'b0;
    repeat (15) @(posedge Clock);
    #1;
    Reset = 1'b0;
    @(posedge Clock); #1;
    chk("midrst_busy", {63'b0, Busy}, 64'd0);
    chk("midrst_hi", {32'b0, Hi}, 64'd0);
    chk("midrst_lo", {32'b0, Lo}, 64'd0);
    chk("midrst_done", {63'b0, Done}, 64'd0);
    m_hi = '0; m_lo = '0;
    Reset = 1'b1;
    done_n = 0;
    repeat (40) begin
      @(posedge Clock); #1;
      if (Done !== 1'b0) done_n++;
    end
    chk("midrst_no_done", 64'(done_n), 64'd0);
    do_op(2'b01, 32'd6, 32'd7, -1);
    chk("post_rst_lo_const", {32'b0, Lo}, 64'd42);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
